// File: rtl/ir_queue.sv
// ir_queue: DEPTH-entry FWFT queue of {pc, instr} between fetch and decode
module ir_queue #(
  parameter int IW = 32,
  parameter int AW = 32,
  parameter int DEPTH = 4,
  parameter logic [IW-1:0] NOP = IW'(32'h00000013)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [IW-1:0]              in_instr,
  input  logic [AW-1:0]              in_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [IW-1:0]              out_instr,
  output logic [AW-1:0]              out_pc,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [IW-1:0] mem_instr [DEPTH];
  logic [AW-1:0] mem_pc [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic push, pop;
  // handshakes and head presentation come only from registered state
  always_comb begin
    in_ready  = count != CW'(DEPTH);
    out_valid = count != '0;
    push      = in_valid & in_ready;
    pop       = out_valid & out_ready;
    out_instr = out_valid ? mem_instr[rd_ptr] : NOP;
    out_pc    = out_valid ? mem_pc[rd_ptr] : '0;
  end
  // pointers, occupancy and storage; flush outranks push and pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_instr[i] <= NOP;
        mem_pc[i]    <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem_instr[wr_ptr] <= in_instr;
        mem_pc[wr_ptr]    <= in_pc;
        wr_ptr            <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: doc/ir_queue.md
# ir_queue

Parametrised instruction register/queue between fetch and decode. It replaces the single write-enabled instruction register with a DEPTH-entry FIFO of {pc, instruction} pairs and adds valid/ready handshakes on both sides. It also adds a synchronous flush for branch/jump redirects, and emits a NOP whenever it is empty. The queue sits at the IF/ID boundary: the fetch unit pushes and the decode stage pops.

## Interface
Parameters:
- IW, 32: instruction width in bits.
- AW, 32: PC width in bits.
- DEPTH, 4: number of entries. Must be a power of two, at least 2.
- NOP, 32'h00000013: instruction presented when empty (RISC-V `addi x0,x0,0`). Width IW.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous discard of all entries.
- in_valid  input  1  fetch offers an entry.
- in_ready  output  1  queue can accept an entry.
- in_instr  input  IW  instruction to push.
- in_pc  input  AW  PC of in_instr.
- out_valid  output  1  head entry present.
- out_ready  input  1  decode consumes the head.
- out_instr  output  IW  head instruction, or NOP when empty.
- out_pc  output  AW  head PC, or 0 when empty.
- count  output  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.

## Operation
- Storage: DEPTH entries of {pc, instr}, plus wr_ptr and rd_ptr of $clog2(DEPTH) bits and count.
  - Pointers wrap modulo DEPTH by natural overflow.
- Handshake events:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
- Ready/valid rules:
  - in_ready = (count != DEPTH). It depends only on registered state, with no combinational path from out_ready. A full queue refuses a push even if a pop happens in the same cycle.
  - out_valid = (count != 0).
- Output data:
  - out_instr and out_pc show the entry at rd_ptr when out_valid is 1.
  - Otherwise they show NOP and 0.
  - The queue is first-word fall-through: the head is readable combinationally from the registered storage.
- Push: writes {in_pc, in_instr} at wr_ptr, then wr_ptr += 1.
- Pop: rd_ptr += 1.
- Count update:
  - push only: count += 1.
  - pop only: count -= 1.
  - both: count unchanged.
- Flush (priority over push and pop):
  - count, wr_ptr and rd_ptr go to 0.
  - A push in the same cycle is discarded; in_ready is still driven by the pre-flush state.
  - A pop in the same cycle has no effect beyond the flush.
  - Storage contents need not be cleared.
- Reset (rst_n low):
  - Takes effect immediately and asynchronously, including mid-operation.
  - count, wr_ptr and rd_ptr go to 0.
  - All storage entries go to {0, NOP}.
  - Any partially completed handshake is lost.
- Input stability:
  - in_instr and in_pc are don't-care when in_valid is 0.
  - The queue never pops or pushes on an X handshake (bench assertion).

## Timing
- Output values after reset: in_ready=1, out_valid=0, out_instr=NOP, out_pc=0, count=0.
- Latency: an entry pushed at edge N appears on out_* after edge N (same cycle as count becomes ≥1). Push-to-out latency is 1 cycle.
- A pop at edge N exposes the next entry, or NOP, after edge N.
- Throughput: one push and one pop per cycle sustained while 0 < count < DEPTH.
- Full, empty and wrap boundaries:
  - count == DEPTH gives in_ready=0.
  - count == 0 gives out_valid=0.
  - Pointer wrap from DEPTH-1 to 0 is seamless.
- Flush at edge N: after edge N, out_valid=0 and in_ready=1. A push at edge N+1 is accepted normally.
- Reset release: the first push is accepted on the first rising edge with rst_n high.

## Test plan
- Reset then idle: hold rst_n=0 for 2 cycles, then release → in_ready=1, out_valid=0, out_instr=32'h00000013, out_pc=0, count=0.
- Fill and drain with DEPTH=4:
  - Push instructions 0x11111111..0x44444444 with PCs 0x0,0x4,0x8,0xC, keeping out_ready=0.
  - After the 4th push: count=4, in_ready=0, and a 5th push is not accepted.
  - Then set out_ready=1: out_pc reads 0x0,0x4,0x8,0xC in order, then out_valid=0 and out_instr=NOP.
- Streaming wrap: hold in_valid=1 and out_ready=1 for 12 cycles, starting from count=1 → count stays 1, outputs appear in order with no loss or duplication, and pointers wrap 3 times.
- Full queue with pop: at count=4 assert in_valid and out_ready together → pop happens, push refused, count=3. The next cycle the push is accepted and count=4.
- Flush with simultaneous push and pop: at count=2 assert flush, in_valid and out_ready → after the edge count=0, out_valid=0, out_instr=NOP. The flushed push never appears on out_*.
- Async reset mid-stream: drop rst_n between edges at count=3 → outputs go to reset values immediately, without waiting for a clock edge. After release, behaviour matches a fresh reset.
